// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage_pkg                                                            |
// | Shared pipeline widths, ALU op encodings and the packed control word.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package id_ex_stage_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_ALU_OP_W = 4;

  localparam logic [DEF_ALU_OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [DEF_ALU_OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [DEF_ALU_OP_W-1:0] ALU_ADD = 4'd2;
  localparam logic [DEF_ALU_OP_W-1:0] ALU_SUB = 4'd6;
  localparam logic [DEF_ALU_OP_W-1:0] ALU_SLT = 4'd7;
  localparam logic [DEF_ALU_OP_W-1:0] ALU_NOR = 4'd12;

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    alu_src;
    logic                    branch;
    logic [DEF_ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_operand_bypass.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | operand_bypass                                                             |
// | Register 0 forcing and same-cycle write-back bypass for one source.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module operand_bypass
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] operand
);

  logic w_addr_zero;
  logic w_wb_hit;

  assign w_addr_zero = (addr == '0);
  assign w_wb_hit    = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == addr);

  always_comb begin
    operand = rf_data;
    if (w_addr_zero) begin
      operand = '0;
    end else if (w_wb_hit) begin
      operand = wb_write_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage                                                                |
// | ID/EX pipeline register with operand bypass, load-use stall and flush.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int ALU_OP_W = DEF_ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_uses_rt,
  input  logic [15:0]         id_imm16,
  input  logic                id_imm_zext,
  input  logic                id_reg_dst,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic                id_branch,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2,
  input  logic                wb_reg_write,
  input  logic [REG_AW-1:0]   wb_write_reg,
  input  logic [DATA_W-1:0]   wb_write_data,
  input  logic                flush,
  output logic                stall,
  output logic                ex_valid,
  output logic [REG_AW-1:0]   ex_rs,
  output logic [REG_AW-1:0]   ex_rt,
  output logic [REG_AW-1:0]   ex_dest,
  output logic [DATA_W-1:0]   ex_data1,
  output logic [DATA_W-1:0]   ex_data2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic                ex_branch,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [31:0]         stall_count
);

  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic [DATA_W-1:0] w_imm;
  logic [REG_AW-1:0] w_dest;
  logic              w_hazard;
  logic              w_load;
  ctrl_t             w_id_ctrl;

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_dest;
  logic [DATA_W-1:0] r_ex_data1;
  logic [DATA_W-1:0] r_ex_data2;
  logic [DATA_W-1:0] r_ex_imm;
  ctrl_t             r_ex_ctrl;
  logic [31:0]       r_stall_count;

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_rs (
    .addr          (id_rs),
    .rf_data       (rf_read_data1),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .operand       (w_op1)
  );

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_rt (
    .addr          (id_rt),
    .rf_data       (rf_read_data2),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .operand       (w_op2)
  );

  assign w_dest = id_reg_dst ? id_rd : id_rt;
  assign w_imm  = id_imm_zext ? {{(DATA_W-16){1'b0}}, id_imm16}
                              : {{(DATA_W-16){id_imm16[15]}}, id_imm16};

  assign w_id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       alu_src:    id_alu_src,
                       branch:     id_branch,
                       alu_op:     id_alu_op};

  // A load in EX whose result an ID source needs is not yet available.
  assign w_hazard = r_ex_valid && r_ex_ctrl.mem_read && (r_ex_dest != '0) && id_valid &&
                    ((r_ex_dest == id_rs) || (id_uses_rt && (r_ex_dest == id_rt)));
  assign stall    = w_hazard && !flush;
  assign w_load   = !flush && !w_hazard && id_valid;

  // Bubbles clear only valid and control; data fields hold to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_dest  <= '0;
      r_ex_data1 <= '0;
      r_ex_data2 <= '0;
      r_ex_imm   <= '0;
      r_ex_ctrl  <= CTRL_BUBBLE;
    end else if (w_load) begin
      r_ex_valid <= 1'b1;
      r_ex_rs    <= id_rs;
      r_ex_rt    <= id_rt;
      r_ex_dest  <= w_dest;
      r_ex_data1 <= w_op1;
      r_ex_data2 <= w_op2;
      r_ex_imm   <= w_imm;
      r_ex_ctrl  <= w_id_ctrl;
    end else begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign ex_valid      = r_ex_valid;
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign ex_dest       = r_ex_dest;
  assign ex_data1      = r_ex_data1;
  assign ex_data2      = r_ex_data2;
  assign ex_imm        = r_ex_imm;
  assign ex_reg_write  = r_ex_ctrl.reg_write;
  assign ex_mem_read   = r_ex_ctrl.mem_read;
  assign ex_mem_write  = r_ex_ctrl.mem_write;
  assign ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
  assign ex_alu_src    = r_ex_ctrl.alu_src;
  assign ex_branch     = r_ex_ctrl.branch;
  assign ex_alu_op     = r_ex_ctrl.alu_op;
  assign stall_count   = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_ex_stage                                                             |
// | Directed and random stimulus against a behavioural ID/EX model.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_uses_rt, id_imm_zext, id_reg_dst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
  logic [3:0]  id_alu_op;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        stall, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [31:0] ex_data1, ex_data2, ex_imm;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [3:0]  ex_alu_op;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_imm16(id_imm16), .id_imm_zext(id_imm_zext), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_alu_op(id_alu_op),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model state: what EX should hold
  logic        m_valid;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [31:0] m_d1, m_d2, m_imm, m_cnt;
  logic [9:0]  m_ctrl;  // {rw, mr, mw, m2r, asrc, br, alu_op}

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == a) return wb_write_data;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    return m_valid && m_ctrl[8] && (m_dest != 5'd0) && id_valid &&
           (m_dest == id_rs || (id_uses_rt && m_dest == id_rt));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_rs <= '0; m_rt <= '0; m_dest <= '0;
      m_d1 <= '0; m_d2 <= '0; m_imm <= '0; m_ctrl <= '0; m_cnt <= '0;
    end else begin
      if (ref_hazard() && !flush) m_cnt <= m_cnt + 32'd1;
      if (!flush && !ref_hazard() && id_valid) begin
        m_valid <= 1'b1;
        m_rs    <= id_rs;
        m_rt    <= id_rt;
        m_dest  <= id_reg_dst ? id_rd : id_rt;
        m_d1    <= ref_operand(id_rs, rf_read_data1);
        m_d2    <= ref_operand(id_rt, rf_read_data2);
        m_imm   <= id_imm_zext ? {16'h0, id_imm16} : {{16{id_imm16[15]}}, id_imm16};
        m_ctrl  <= {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_alu_op};
      end else begin
        m_valid <= 1'b0;
        m_ctrl  <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ex();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_rs", {27'd0, ex_rs}, {27'd0, m_rs});
    chk("ex_rt", {27'd0, ex_rt}, {27'd0, m_rt});
    chk("ex_dest", {27'd0, ex_dest}, {27'd0, m_dest});
    chk("ex_data1", ex_data1, m_d1);
    chk("ex_data2", ex_data2, m_d2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_ctrl", {22'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                    ex_branch, ex_alu_op}, {22'd0, m_ctrl});
    chk("stall_count", stall_count, m_cnt);
  endtask

  // Inputs are already applied; check stall, clock once, check EX.
  task automatic cycle();
    #1;
    chk("stall", {31'd0, stall}, {31'd0, ref_hazard() && !flush});
    @(posedge clk);
    @(negedge clk);
    chk_ex();
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic uses_rt, input logic reg_dst, input logic mr, input logic rw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt; id_reg_dst = reg_dst;
    id_mem_read = mr; id_reg_write = rw; id_mem_to_reg = mr; id_mem_write = 1'b0;
    id_alu_src = mr; id_branch = 1'b0; id_alu_op = 4'd2; id_imm16 = 16'h0004; id_imm_zext = 1'b0;
  endtask

  task automatic clear_io();
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rf_read_data1 = '0; rf_read_data2 = '0;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk_ex();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        hold;
  logic [31:0] cnt_before;

  initial begin
    clear_io();
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk_ex();

    // Normal pass
    set_instr(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    id_imm16 = 16'h8000; rf_read_data1 = 32'h11; rf_read_data2 = 32'h22;
    cycle();
    chk("np_data1", ex_data1, 32'h11);
    chk("np_data2", ex_data2, 32'h22);
    chk("np_dest", {27'd0, ex_dest}, 32'd5);
    chk("np_imm", ex_imm, 32'hFFFF_8000);
    chk("np_valid", {31'd0, ex_valid}, 32'd1);

    // Asynchronous reset while EX holds a valid instruction
    do_reset();

    // WB bypass on rs, r0 on rt
    set_instr(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    rf_read_data1 = 32'h11; rf_read_data2 = 32'h99;
    wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'hDEAD;
    cycle();
    chk("byp_data1", ex_data1, 32'hDEAD);
    chk("r0_data2", ex_data2, 32'h0);
    wb_reg_write = 1'b0;

    // Load-use: lw r8,4(r1) then add r9,r8,r1
    do_reset();
    set_instr(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    set_instr(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    cycle();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    #1 chk("lu_stall_once", {31'd0, stall}, 32'd0);
    cycle();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_dest", {27'd0, ex_dest}, 32'd9);
    chk("lu_count", stall_count, 32'd1);

    // Masking: rt match without uses_rt, then a load to r0
    set_instr(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    set_instr(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("mask_rt", {31'd0, stall}, 32'd0);
    cycle();
    set_instr(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    set_instr(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("mask_r0", {31'd0, stall}, 32'd0);
    cycle();

    // Flush beats hazard
    set_instr(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    cnt_before = stall_count;
    set_instr(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    #1 chk("fl_stall", {31'd0, stall}, 32'd0);
    cycle();
    chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
    chk("fl_count", stall_count, cnt_before);
    flush = 1'b0;

    // Random traffic; a stalled instruction is re-presented unchanged
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        id_valid = ($urandom_range(0, 99) < 85);
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
        id_uses_rt = 1'($urandom); id_reg_dst = 1'($urandom);
        id_imm16 = 16'($urandom); id_imm_zext = 1'($urandom);
        id_mem_read = ($urandom_range(0, 99) < 40);
        {id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src, id_branch} = 5'($urandom);
        id_alu_op = 4'($urandom);
      end
      rf_read_data1 = $urandom; rf_read_data2 = $urandom;
      wb_reg_write = 1'($urandom); wb_write_reg = 5'($urandom_range(0, 3)); wb_write_data = $urandom;
      flush = ($urandom_range(0, 99) < 10);
      hold = ref_hazard() && !flush;
      cycle();
      @(negedge clk);
      if (i == 200) begin
        do_reset();
        hold = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the MIPS pipeline, directly downstream of the register file. It captures the two register-file read values and the decoded control word into the ID/EX register, bypasses a same-cycle write-back onto the read data, and forces register 0 to read as zero. It detects load-use hazards, stalling IF/ID and injecting a bubble, and honours a branch flush. A free-running stall counter supports performance debug.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- ALU_OP_W, 4, ALU operation code width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  decoded register fields (id_rs/id_rt also drive register-file read_reg1/read_reg2)
- id_uses_rt  in  1  instruction sources rt (R-type, store, beq/bne)
- id_imm16  in  16  raw immediate
- id_imm_zext  in  1  1 = zero-extend immediate, 0 = sign-extend
- id_reg_dst  in  1  1 = destination is rd, 0 = rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  control bits
- id_alu_op  in  ALU_OP_W  ALU operation
- rf_read_data1, rf_read_data2  in  DATA_W  register-file outputs for id_rs/id_rt
- wb_reg_write  in  1  write-back stage writing this cycle
- wb_write_reg  in  REG_AW  write-back destination
- wb_write_data  in  DATA_W  write-back value
- flush  in  1  branch taken; discard the ID instruction
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_dest  out  REG_AW  source fields and resolved destination
- ex_data1, ex_data2, ex_imm  out  DATA_W  operands and extended immediate
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each  registered control
- ex_alu_op  out  ALU_OP_W  registered ALU op
- stall_count  out  32  number of stall cycles since reset

## Operation
- Operand select, per source, in priority order:
  - Address 0 yields 0.
  - If wb_reg_write is high, wb_write_reg is nonzero, and wb_write_reg equals the address, the operand is wb_write_data. This covers the register file writing on the same edge.
  - Otherwise the operand is rf_read_data.
- ex_dest = id_reg_dst ? id_rd : id_rt.
- ex_imm = id_imm_zext ? {16'b0, id_imm16} : {{16{id_imm16[15]}}, id_imm16}.
- Load-use hazard exists when all of the following hold:
  - ex_valid and ex_mem_read are high, and ex_dest is nonzero;
  - ex_dest equals id_rs, or id_uses_rt is high and ex_dest equals id_rt;
  - id_valid is high.
- stall = hazard AND NOT flush.
- Each cycle, exactly one of these actions applies, highest priority first:
  - flush: load a bubble.
  - hazard: load a bubble. The ID instruction stays in IF/ID and is re-presented next cycle.
  - id_valid = 0: load a bubble.
  - Otherwise: load the ID instruction.
- Bubble contents: ex_valid = 0, and all ex_ control bits and ex_alu_op = 0. Data and address fields keep their previous values, so no writes or memory side effects can occur.
- stall_count increments by 1 every cycle stall is high. It wraps from 0xFFFFFFFF to 0.
- The state machine is implicit: each cycle EX is either VALID or BUBBLE, and a hazard can persist for only one cycle because the next EX is a bubble.

## Timing
- Latency: ID inputs appear on ex_ outputs one clock after the capturing edge.
- stall is combinational from the ex_ state and ID inputs, and is valid in the same cycle.
- The bypass is combinational on wb_ inputs in the same cycle; there is no extra latency.
- Asynchronous reset (rst_n low) immediately drives every output register to 0, including ex_valid, all ex_ fields, and stall_count. stall therefore reads 0 during reset.
- Reset mid-hazard: the bubble and counter clear; the first cycle after release loads normally.
- flush and hazard in the same cycle: a bubble is loaded, stall = 0, and stall_count does not increment.
- Bypass and hazard in the same cycle: the hazard wins; the bypassed value is re-evaluated on the retry cycle.

## Structure
- The shared pipeline package holds:
  - DATA_W, REG_AW, ALU_OP_W defaults;
  - the ALU op encodings;
  - a packed control-word typedef (reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op) plus a CTRL_BUBBLE all-zero constant.
- One natural sub-module, operand_bypass: it performs the r0/WB-bypass selection and is instantiated twice, once for rs and once for rt.
- The hazard logic, the pipeline register, and the counter stay in the top module.

## Test plan
- Reset: hold rst_n low mid-run with ex_valid = 1 → all outputs 0 asynchronously, with no clock edge needed; stall_count = 0.
- Normal pass: id_rs = 3, id_rt = 4, rf data 0x11/0x22, reg_dst = 1, rd = 5, imm16 = 0x8000, zext = 0 → next cycle ex_data1 = 0x11, ex_data2 = 0x22, ex_dest = 5, ex_imm = 0xFFFF8000, ex_valid = 1.
- WB bypass and r0:
  - wb writes r3 = 0xDEAD while id_rs = 3 and rf_read_data1 = 0x11 → ex_data1 = 0xDEAD.
  - id_rt = 0 with rf_read_data2 = 0x99 → ex_data2 = 0.
- Load-use: lw to r8 in EX, then add r9,r8,r1 in ID → stall = 1 for exactly one cycle. The next EX is a bubble (ex_valid = 0, ex_reg_write = 0), then the add loads; stall_count = 1.
- Hazard masking: the same load followed by an instruction with id_rt = 8 and id_uses_rt = 0 → no stall. A load to r0 → no stall.
- Flush priority: hazard and flush together → stall = 0, a bubble is loaded, and stall_count is unchanged.
- Counter wrap: force 0xFFFFFFFF stall cycles (or preload stall_count in simulation), then one stall → stall_count = 0.
